// File: rtl/udm_gpio_ctrl.sv
// Memory-mapped GPIO controller: synchronised and debounced inputs with edge capture and a level interrupt,
// plus atomic set/clear/toggle on the outputs. Single-cycle acknowledged slave on the core data bus.
module udm_gpio_ctrl #(
  parameter int                 NUM_IN    = 16,
  parameter int                 NUM_OUT   = 16,
  parameter int                 DB_CYCLES = 1000000,
  parameter logic [NUM_OUT-1:0] OUT_RST   = {NUM_OUT{1'b0}}
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  input  logic               bus_req_i,
  input  logic               bus_we_i,
  input  logic [3:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  output logic               bus_ack_o,
  output logic [31:0]        bus_rdata_o,
  input  logic [NUM_IN-1:0]  gpio_bi,
  output logic [NUM_OUT-1:0] gpio_bo,
  output logic               irq_o
);

  localparam int CW          = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int CNT_MAX_INT = (DB_CYCLES > 0) ? DB_CYCLES - 1 : 0;

  logic [NUM_IN-1:0]  s1_r, s2_r, stable_r, stable_d_r;
  logic [NUM_IN-1:0]  rise_en_r, fall_en_r, edge_st_r, irq_en_r;
  logic [NUM_OUT-1:0] out_r;
  logic               ack_r, irq_r;
  logic [31:0]        rdata_r;

  logic               wr_s;
  logic [NUM_IN-1:0]  wd_in_s, rise_s, fall_s, set_s, clr_s, edge_nxt_s;
  logic [NUM_OUT-1:0] wd_out_s, out_nxt_s;
  logic [31:0]        rd_mux_s;
  logic               unused_wdata_s;

  assign wr_s           = bus_req_i & bus_we_i;
  assign wd_in_s        = bus_wdata_i[NUM_IN-1:0];
  assign wd_out_s       = bus_wdata_i[NUM_OUT-1:0];
  assign unused_wdata_s = ^bus_wdata_i;

  // Two-flop synchroniser for the asynchronous board inputs
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      s1_r <= {NUM_IN{1'b0}};
      s2_r <= {NUM_IN{1'b0}};
    end else begin
      s1_r <= gpio_bi;
      s2_r <= s1_r;
    end
  end

  // A change must hold at s2 for DB_CYCLES clocks before it is accepted as stable
  if (DB_CYCLES == 0) begin : g_nodb
    // Debouncing disabled: stable simply follows the synchroniser
    always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
        stable_r <= {NUM_IN{1'b0}};
      end else begin
        stable_r <= s2_r;
      end
    end
  end else begin : g_db
    logic [CW-1:0] cnt_r [NUM_IN];

    // Per-channel debounce counter and stable bit
    always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!srst_n_i) begin
          cnt_r[i]    <= {CW{1'b0}};
          stable_r[i] <= 1'b0;
        end else if (s2_r[i] == stable_r[i]) begin
          cnt_r[i]    <= {CW{1'b0}};
        end else if (cnt_r[i] == CW'(CNT_MAX_INT)) begin
          cnt_r[i]    <= {CW{1'b0}};
          stable_r[i] <= s2_r[i];
        end else begin
          cnt_r[i]    <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign rise_s = stable_r & ~stable_d_r;
  assign fall_s = ~stable_r & stable_d_r;
  assign set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);

  // Write-1-to-clear mask; a coincident capture overrides the clear
  always_comb begin
    clr_s = {NUM_IN{1'b0}};
    if (wr_s && (bus_addr_i == 4'd7)) begin
      clr_s = wd_in_s;
    end else begin
      clr_s = {NUM_IN{1'b0}};
    end
    edge_nxt_s = (edge_st_r & ~clr_s) | set_s;
  end

  // Next OUT value for direct and atomic writes
  always_comb begin
    out_nxt_s = out_r;
    if (wr_s) begin
      case (bus_addr_i)
        4'd1:    out_nxt_s = wd_out_s;
        4'd2:    out_nxt_s = out_r | wd_out_s;
        4'd3:    out_nxt_s = out_r & ~wd_out_s;
        4'd4:    out_nxt_s = out_r ^ wd_out_s;
        default: out_nxt_s = out_r;
      endcase
    end else begin
      out_nxt_s = out_r;
    end
  end

  // Read multiplexer over the pre-edge register state
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus_addr_i)
      4'd0:    rd_mux_s = 32'(stable_r);
      4'd1:    rd_mux_s = 32'(out_r);
      4'd5:    rd_mux_s = 32'(rise_en_r);
      4'd6:    rd_mux_s = 32'(fall_en_r);
      4'd7:    rd_mux_s = 32'(edge_st_r);
      4'd8:    rd_mux_s = 32'(irq_en_r);
      4'd9:    rd_mux_s = {16'h0000, 8'(NUM_OUT), 8'(NUM_IN)};
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Control, status and output registers
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      out_r      <= OUT_RST;
      rise_en_r  <= {NUM_IN{1'b0}};
      fall_en_r  <= {NUM_IN{1'b0}};
      irq_en_r   <= {NUM_IN{1'b0}};
      edge_st_r  <= {NUM_IN{1'b0}};
      stable_d_r <= {NUM_IN{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      out_r      <= out_nxt_s;
      edge_st_r  <= edge_nxt_s;
      stable_d_r <= stable_r;
      irq_r      <= |(edge_st_r & irq_en_r);
      if (wr_s) begin
        case (bus_addr_i)
          4'd5:    rise_en_r <= wd_in_s;
          4'd6:    fall_en_r <= wd_in_s;
          4'd8:    irq_en_r  <= wd_in_s;
          default: rise_en_r <= rise_en_r;
        endcase
      end else begin
        rise_en_r <= rise_en_r;
      end
    end
  end

  // Bus response: one-cycle ack, read data zero outside the ack cycle
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ack_r   <= bus_req_i;
      rdata_r <= (bus_req_i && !bus_we_i) ? rd_mux_s : 32'h0000_0000;
    end
  end

  assign bus_ack_o   = ack_r;
  assign bus_rdata_o = rdata_r;
  assign gpio_bo     = out_r;
  assign irq_o       = irq_r;

endmodule

// File: tb/tb_udm_gpio_ctrl.sv
// Scoreboard bench for udm_gpio_ctrl: bus requests push expected acks/data, a negedge monitor pops and compares.
module tb_udm_gpio_ctrl;

  logic        clk = 1'b0;
  logic        srst_n_i = 1'b0;
  logic        bus_req_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic [3:0]  bus_addr_i = 4'd0;
  logic [31:0] bus_wdata_i = 32'h0;
  logic        bus_ack_o;
  logic [31:0] bus_rdata_o;
  logic [15:0] gpio_bi = 16'h0000;
  logic [15:0] gpio_bo;
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [31:0] data;
    logic [3:0]  addr;
  } exp_t;
  exp_t sb_q[$];

  udm_gpio_ctrl #(
    .NUM_IN(16), .NUM_OUT(16), .DB_CYCLES(8), .OUT_RST(16'hA5A5)
  ) dut (
    .clk_i(clk), .srst_n_i(srst_n_i), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_ack_o(bus_ack_o),
    .bus_rdata_o(bus_rdata_o), .gpio_bi(gpio_bi), .gpio_bo(gpio_bo), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the oldest expectation in cycle and (for reads) data
  always @(negedge clk) begin
    exp_t e;
    if (bus_ack_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: cycle %0d rdata %h, no request outstanding", cyc, bus_rdata_o);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || (e.chk && bus_rdata_o !== e.data)) begin
          errors++;
          $display("FAIL ack_addr%0d: got cycle %0d data %h, expected cycle %0d data %h",
                   e.addr, cyc, bus_rdata_o, e.cyc, e.data);
        end
      end
    end else begin
      checks++;
      if (bus_rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL rdata_idle: got %h expected 00000000 at cycle %0d", bus_rdata_o, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_ack_addr%0d: no ack at cycle %0d, expected at %0d", e.addr, cyc, e.cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request for the next edge, record the expected ack, then move to the next negedge
  task automatic access(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
    bus_req_i   = 1'b1;
    bus_we_i    = we;
    bus_addr_i  = a;
    bus_wdata_i = d;
    sb_q.push_back('{cyc: cyc + 1, chk: !we, data: exp, addr: a});
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    access(1'b0, a, 32'h0, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    access(1'b1, a, d, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus_req_i = 1'b0;
      bus_we_i  = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    srst_n_i = 1'b1;

    // Reset state and ID register
    chk("rst_gpio_bo", 32'(gpio_bo), 32'h0000_A5A5);
    chk("rst_irq", 32'(irq_o), 32'h0);
    rd(4'd9, 32'h0000_1010);
    rd(4'd1, 32'h0000_A5A5);
    rd(4'd0, 32'h0);
    rd(4'd7, 32'h0);
    idle(1);

    // Atomic output updates, back to back
    wr(4'd1, 32'h0000_00F0);
    wr(4'd2, 32'h0000_000F);
    wr(4'd3, 32'h0000_0030);
    wr(4'd4, 32'h0000_0101);
    rd(4'd1, 32'h0000_01CE);
    idle(1);
    chk("gpio_bo_atomic", 32'(gpio_bo), 32'h0000_01CE);
    rd(4'd2, 32'h0);
    wr(4'd12, 32'hFFFF_FFFF);
    rd(4'd12, 32'h0);
    rd(4'd1, 32'h0000_01CE);
    wr(4'd1, 32'hFFFF_0001);
    rd(4'd1, 32'h0000_0001);
    idle(1);
    chk("gpio_bo_trunc", 32'(gpio_bo), 32'h0000_0001);

    // Debounce latency on channel 3 and edge capture into IRQ
    wr(4'd5, 32'h0000_0018);
    wr(4'd6, 32'h0000_0000);
    wr(4'd8, 32'h0000_0008);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) gpio_bi[3] = 1'b1;
      rd(4'd0, (i >= 10) ? 32'h0000_0008 : 32'h0);
      if (i == 10) chk("irq_before_edge", 32'(irq_o), 32'h0);
      if (i == 11) chk("irq_after_edge", 32'(irq_o), 32'h1);
    end
    rd(4'd7, 32'h0000_0008);

    // Short glitch on channel 4 must not reach stable
    gpio_bi[4] = 1'b1;
    idle(5);
    gpio_bi[4] = 1'b0;
    idle(15);
    rd(4'd0, 32'h0000_0008);
    rd(4'd7, 32'h0000_0008);

    // W1C clears status; irq drops one clock later; falling edge not enabled
    wr(4'd7, 32'h0000_0008);
    chk("irq_hold_after_w1c", 32'(irq_o), 32'h1);
    idle(1);
    chk("irq_clear", 32'(irq_o), 32'h0);
    rd(4'd7, 32'h0);
    gpio_bi[3] = 1'b0;
    idle(15);
    rd(4'd0, 32'h0);
    rd(4'd7, 32'h0);
    idle(1);
    chk("irq_no_fall", 32'(irq_o), 32'h0);

    // Capture and W1C on the same edge: capture wins
    gpio_bi[3] = 1'b1;
    idle(10);
    wr(4'd7, 32'h0000_0008);
    rd(4'd7, 32'h0000_0008);
    rd(4'd0, 32'h0000_0008);
    idle(1);
    chk("irq_set_wins", 32'(irq_o), 32'h1);

    // Reset during an outstanding request; partly counted channel 6 must restart
    gpio_bi[6] = 1'b1;
    idle(6);
    bus_req_i   = 1'b1;
    bus_we_i    = 1'b1;
    bus_addr_i  = 4'd1;
    bus_wdata_i = 32'h0000_1234;
    srst_n_i    = 1'b0;
    @(negedge clk);
    srst_n_i  = 1'b1;
    bus_req_i = 1'b0;
    chk("rst2_gpio_bo", 32'(gpio_bo), 32'h0000_A5A5);
    chk("rst2_irq", 32'(irq_o), 32'h0);
    for (int i = 0; i < 12; i++) begin
      rd(4'd0, (i >= 10) ? 32'h0000_0048 : 32'h0);
    end
    rd(4'd7, 32'h0);
    rd(4'd5, 32'h0);
    rd(4'd1, 32'h0000_A5A5);
    idle(3);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udm_gpio_ctrl.md
Name: udm_gpio_ctrl

Overview:
- Parametrised memory-mapped GPIO controller for the DLX/UDM SoC family, replacing direct wiring of board switches and LEDs to the core's gpio_bi/gpio_bo.
- Provides per-channel input synchronisation and debouncing, atomic output set/clear/toggle, and per-channel rising/falling edge capture with a level interrupt.
- Sits on the core's data-bus split as a slave; board tops connect SW to gpio_bi and LED to gpio_bo.

Parameters:
- NUM_IN, 16, input channel count (1..32).
- NUM_OUT, 16, output channel count (1..32).
- DB_CYCLES, 1000000, debounce hold time in clocks; 0 disables debouncing (synchroniser only).
- OUT_RST, 0, reset value of the OUT register (NUM_OUT bits).

Ports:
- clk_i  in  1  system clock.
- srst_n_i  in  1  reset; one clock, synchronous, active-low.
- bus_req_i  in  1  access request, sampled every clock.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_i  in  4  word address.
- bus_wdata_i  in  32  write data.
- bus_ack_o  out  1  one-cycle acknowledge.
- bus_rdata_o  out  32  read data, valid while bus_ack_o = 1.
- gpio_bi  in  NUM_IN  asynchronous board inputs.
- gpio_bo  out  NUM_OUT  registered outputs, equal to OUT.
- irq_o  out  1  registered level interrupt.

Behaviour:
- Reset, synchronous and active-low:
  - OUT = OUT_RST.
  - All other registers, synchroniser flops, debounce counters and stable bits = 0.
  - bus_ack_o = 0, bus_rdata_o = 0, irq_o = 0.
  - A reset asserted mid-transfer suppresses that transfer's ack.
- Bus handshake:
  - A request sampled at edge k produces bus_ack_o = 1 for exactly the cycle after k.
  - Writes take effect at edge k.
  - Read data reflects register state before edge k.
  - One access per cycle, so back-to-back requests are acked on consecutive cycles.
  - bus_rdata_o = 0 when bus_ack_o = 0.
- Register map (word address; unused bits read 0):
  - 0 IN (RO): debounced stable inputs.
  - 1 OUT (RW).
  - 2 OUT_SET (WO): OUT |= wdata.
  - 3 OUT_CLR (WO): OUT &= ~wdata.
  - 4 OUT_TGL (WO): OUT ^= wdata.
  - Addresses 2..4 read 0.
  - 5 RISE_EN (RW).
  - 6 FALL_EN (RW).
  - 7 EDGE_ST: read; write-1-to-clear.
  - 8 IRQ_EN (RW).
  - 9 INFO (RO): [15:8] = NUM_OUT, [7:0] = NUM_IN.
  - 10..15: read 0, writes ignored but still acked.
- Input path, per channel:
  - Two-flop synchroniser (s1, s2), then a debounce counter of width clog2(DB_CYCLES + 1).
  - If s2 == stable: counter = 0.
  - Otherwise, if counter == DB_CYCLES - 1: stable = s2 and counter = 0.
  - Otherwise: counter + 1.
  - A held input change appears in stable DB_CYCLES + 2 clocks after first sampled.
  - A glitch shorter than DB_CYCLES clocks at s2 never reaches stable.
  - DB_CYCLES = 0: stable = s2, so latency is 3 clocks.
- Edge capture:
  - rise = stable & ~stable_d; fall = ~stable & stable_d, where stable_d is the previous stable.
  - EDGE_ST[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Simultaneous set and W1C on the same bit: set wins.
  - Inputs high at reset release produce a rise event after debounce.
- Interrupt: irq_o = registered |(EDGE_ST & IRQ_EN); it updates one clock after EDGE_ST or IRQ_EN changes.
- Widths: write data bits above NUM_OUT / NUM_IN are ignored. gpio_bo follows OUT with zero extra latency (same flop).

Test Plan:
1. Reset with OUT_RST = 16'hA5A5 → gpio_bo = A5A5, irq_o = 0. Read addr 9 → 0x00001010, acked exactly 1 cycle after req.
2. Write OUT = 0x00F0, then SET 0x000F, CLR 0x0030, TGL 0x0101 → gpio_bo = 0x01CE. Back-to-back requests each acked once on consecutive cycles.
3. DB_CYCLES = 8: gpio_bi[3] rises and holds → IN[3] = 1 exactly 10 clocks later. A 5-cycle pulse on gpio_bi[4] → IN[4] stays 0, EDGE_ST unchanged.
4. RISE_EN = 0x8, IRQ_EN = 0x8, gpio_bi[3] rises → EDGE_ST = 0x8, irq_o = 1 the next clock. Write 0x8 to addr 7 → irq_o = 0. A falling edge with FALL_EN = 0 → no set.
5. W1C of EDGE_ST[3] in the same cycle as a new rise on channel 3 → bit remains 1.
6. Drop srst_n_i for one clock during an outstanding request → no ack, OUT = OUT_RST, EDGE_ST = 0, counters cleared.
